// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
package imm_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned IMM_MAX_W = 64;
  localparam int unsigned OPC_W     = 7;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

  // Immediate is stored at the widest supported XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [IMM_MAX_W-1:0] imm;
    fmt_e                 fmt;
    logic                 illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{inst: '0, imm: '0, fmt: FMT_R, illegal: 1'b0};

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode -> immediate/format decode for all base RISC-V formats.
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   imm_c,
  output fmt_e              fmt_c,
  output logic              illegal_c
);

  localparam bit RV64 = (XLEN == 64);

  logic [OPC_W-1:0] opcode;
  logic             is_shift;
  logic [XLEN-1:0]  imm_i;
  logic [XLEN-1:0]  imm_s;
  logic [XLEN-1:0]  imm_b;
  logic [XLEN-1:0]  imm_u;
  logic [XLEN-1:0]  imm_j;
  logic [XLEN-1:0]  shamt_op;
  logic [XLEN-1:0]  shamt_w;

  assign opcode   = inst[6:0];
  assign is_shift = (inst[13:12] == 2'b01);

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  // RV64 OP-IMM shifts carry a 6-bit shamt; word shifts and RV32 use 5 bits.
  assign shamt_op = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
  assign shamt_w  = XLEN'(inst[24:20]);

  always_comb begin
    imm_c     = '0;
    fmt_c     = FMT_ILL;
    illegal_c = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        fmt_c     = FMT_I;
        illegal_c = 1'b0;
        imm_c     = imm_i;
      end
      OPC_OP_IMM: begin
        fmt_c     = FMT_I;
        illegal_c = 1'b0;
        imm_c     = is_shift ? shamt_op : imm_i;
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          fmt_c     = FMT_I;
          illegal_c = 1'b0;
          imm_c     = is_shift ? shamt_w : imm_i;
        end
      end
      OPC_STORE: begin
        fmt_c     = FMT_S;
        illegal_c = 1'b0;
        imm_c     = imm_s;
      end
      OPC_BRANCH: begin
        fmt_c     = FMT_B;
        illegal_c = 1'b0;
        imm_c     = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_c     = FMT_U;
        illegal_c = 1'b0;
        imm_c     = imm_u;
      end
      OPC_JAL: begin
        fmt_c     = FMT_J;
        illegal_c = 1'b0;
        imm_c     = imm_j;
      end
      OPC_OP: begin
        fmt_c     = FMT_R;
        illegal_c = 1'b0;
      end
      OPC_OP_32: begin
        if (RV64) begin
          fmt_c     = FMT_R;
          illegal_c = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode stage followed by a head/skid output buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter bit          SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_imm,
  output fmt_e              out_fmt,
  output logic              out_illegal
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  entry_t          in_entry;

  imm_fmt_decode #(.XLEN(XLEN)) u_dec (
    .inst      (in_inst),
    .imm_c     (dec_imm),
    .fmt_c     (dec_fmt),
    .illegal_c (dec_illegal)
  );

  assign in_entry = '{inst: in_inst, imm: IMM_MAX_W'(dec_imm), fmt: dec_fmt, illegal: dec_illegal};

  occ_e   state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q;
  logic   push, pop;

  // Without a skid slot the stage may only accept when its single register drains.
  assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  // State register and buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      head_q      <= ENTRY_RESET;
      skid_q      <= ENTRY_RESET;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= (state_d != OCC_EMPTY);
    end
  end

  // Occupancy transitions; the head always feeds the outputs, the skid refills it on pop.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    in_ready_d = 1'b1;
    unique case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          skid_d  = in_entry;
          state_d = OCC_TWO;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_d = skid_q;
          if (push) begin
            skid_d = in_entry;
          end else begin
            state_d = OCC_ONE;
          end
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush wins over any same-cycle push; payload fields are left stale.
    if (flush) begin
      state_d = OCC_EMPTY;
    end
    in_ready_d = (state_d != OCC_TWO);
  end

  assign out_valid   = out_valid_q;
  assign out_inst    = head_q.inst;
  assign out_imm     = head_q.imm[XLEN-1:0];
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV64 skid build plus an RV32 build without skid.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam logic [31:0] I_LD    = 32'hFF813283;
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
  localparam logic [31:0] I_LUI   = 32'h800000B7;
  localparam logic [31:0] I_SLLI  = 32'h03F09093;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_SD    = 32'h00113423;
  localparam logic [31:0] I_JAL   = 32'hFF9FF06F;
  localparam logic [31:0] I_ADD   = 32'h002080B3;
  localparam logic [31:0] I_ADDIW = 32'hFFF0809B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_inst;
  logic [63:0] out_imm;
  fmt_e        out_fmt;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_inst32;
  logic [31:0] out_imm32;
  fmt_e        out_fmt32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .out_valid(out_valid32), .out_ready(out_ready), .out_inst(out_inst32),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] inst, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_inst"}, 64'(out_inst), 64'(inst));
    chk({tag, "_imm"}, out_imm, imm);
    chk({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
    chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'(FMT_R));
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst_valid32", 64'(out_valid32), 64'd0);
    chk("rst_ready32", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming decode, one instruction per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = I_LD;
    step();
    chk_out("ld", I_LD, 64'hFFFFFFFFFFFFFFF8, FMT_I, 1'b0);
    chk("ld_imm32", 64'(out_imm32), 64'h00000000FFFFFFF8);
    in_inst = I_BEQ;
    step();
    chk_out("beq", I_BEQ, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
    in_inst = I_LUI;
    step();
    chk_out("lui", I_LUI, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
    chk("lui_imm32", 64'(out_imm32), 64'h0000000080000000);
    in_inst = I_SLLI;
    step();
    chk_out("slli", I_SLLI, 64'd63, FMT_I, 1'b0);
    chk("slli_imm32", 64'(out_imm32), 64'd31);
    in_inst = I_ILL;
    step();
    chk_out("ill", I_ILL, 64'd0, FMT_ILL, 1'b1);
    in_inst = I_SD;
    step();
    chk_out("sd", I_SD, 64'd8, FMT_S, 1'b0);
    in_inst = I_JAL;
    step();
    chk_out("jal", I_JAL, 64'hFFFFFFFFFFFFFFF8, FMT_J, 1'b0);
    in_inst = I_ADD;
    step();
    chk_out("add", I_ADD, 64'd0, FMT_R, 1'b0);
    in_inst = I_ADDIW;
    step();
    chk_out("addiw", I_ADDIW, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
    chk("addiw_ill32", 64'(out_illegal32), 64'd1);
    chk("addiw_fmt32", 64'(out_fmt32), 64'(FMT_ILL));
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A and B accepted, C held until the consumer drains
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = I_LD;
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_inst", 64'(out_inst), 64'(I_LD));
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    chk("bp_s0_ready_low", 64'(in_ready32), 64'd0);
    in_inst = I_SD;
    step();
    chk("bp_b_ready", 64'(in_ready), 64'd0);
    chk("bp_b_head", 64'(out_inst), 64'(I_LD));
    in_inst = I_BEQ;
    step();
    chk("bp_c_ready", 64'(in_ready), 64'd0);
    chk("bp_c_head", 64'(out_inst), 64'(I_LD));
    out_ready = 1'b1;
    #1;
    chk("bp_s0_ready_comb", 64'(in_ready32), 64'd1);
    step();
    chk_out("bp_out_b", I_SD, 64'd8, FMT_S, 1'b0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp_out_c", I_BEQ, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with the buffer full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = I_LD;
    step();
    in_inst = I_SD;
    step();
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    in_inst = I_ILL;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_full_valid", 64'(out_valid), 64'd0);
    chk("fl_full_ready_after", 64'(in_ready), 64'd1);

    // Flush coinciding with an accepted input discards that input
    in_valid = 1'b1;
    in_inst  = I_LD;
    step();
    chk("fl_one_valid", 64'(out_valid), 64'd1);
    in_inst = I_ILL;
    flush   = 1'b1;
    chk("fl_push_ready", 64'(in_ready), 64'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_push_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    chk("fl_push_never", 64'(out_valid), 64'd0);

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = I_LD;
    step();
    in_inst = I_SD;
    step();
    in_valid = 1'b0;
    chk("ar_held_valid", 64'(out_valid), 64'd1);
    chk("ar_held_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_drop", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_inst", 64'(out_inst), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = I_LD;
    step();
    in_valid = 1'b0;
    chk_out("ar_ld", I_LD, 64'hFFFFFFFFFFFFFFF8, FMT_I, 1'b0);
    step();
    chk("ar_drain", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RISC-V decode path. Covers all base formats: I, S, B, U, J, plus shift-amount forms.
- Accepts one instruction per cycle over a valid/ready handshake. Returns the sign-extended immediate, format code and illegal flag one cycle later.
- A 2-entry skid buffer decouples decode from execute backpressure. Sits between instruction fetch and the register-read/execute stage.

Parameters:
- XLEN, 64, immediate/datapath width; legal values 32 or 64.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (branch mispredict/trap).
- in_valid  input  1  in_inst is valid.
- in_ready  output  1  block accepts in_inst this cycle.
- in_inst  input  32  raw instruction word.
- out_valid  output  1  output entry valid.
- out_ready  input  1  consumer accepts the output entry.
- out_inst  output  32  instruction passed through with its immediate.
- out_imm  output  XLEN  sign-/zero-extended immediate.
- out_fmt  output  3  format code (fmt_e).
- out_illegal  output  1  opcode not recognised.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: out_valid=0, out_inst=0, out_imm=0, out_fmt=FMT_R, out_illegal=0, both entries empty.
  - SKID=1: in_ready resets to 1.
  - SKID=0: in_ready is combinational.
  - Asserting rst mid-operation drops all entries immediately.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustained throughput 1/cycle. Strict FIFO order; no loss or duplication.
- Skid buffer (SKID=1):
  - Occupancy states EMPTY, ONE, TWO. Transitions:
    - push only: +1.
    - pop only: -1.
    - push and pop together: unchanged.
  - in_ready = registered !(TWO), or !(ONE with a push and no pop in the previous cycle); i.e. in_ready is low only when the skid slot is occupied.
  - Outputs always come from the head register. The skid entry moves to the head on pop.
- SKID=0: in_ready = !out_valid || out_ready.
- flush: on the next edge both entries are invalidated and in_ready=1. A simultaneous input transfer is discarded (flush wins). Output fields other than out_valid may hold stale data.
- Decode table, by opcode inst[6:0]:
  - 0000011 LOAD, 0010011 OP-IMM, 0011011 OP-IMM-32, 1100111 JALR -> FMT_I, imm = sext(inst[31:20]).
  - 0100011 STORE -> FMT_S, imm = sext({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH -> FMT_B, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC -> FMT_U, imm = sext({inst[31:12], 12'b0}); for XLEN=32 no extension is needed.
  - 1101111 JAL -> FMT_J, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0110011 OP, 0111011 OP-32 -> FMT_R, imm = 0.
  - 1110011 SYSTEM, 0001111 MISC-MEM -> FMT_I, imm = sext(inst[31:20]).
  - Anything else -> FMT_ILL, out_illegal=1, imm = 0.
- Shift immediates (funct3 001/101):
  - OP-IMM: imm = zext(inst[25:20]) when XLEN=64, zext(inst[24:20]) when XLEN=32.
  - OP-IMM-32: imm = zext(inst[24:20]).
- All sign extension replicates inst[31] to XLEN.
- OP-IMM-32 and OP-32 are decoded as illegal when XLEN=32.

Decomposition:
- Package imm_pkg:
  - fmt_e enum: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_ILL=7.
  - Opcode localparams.
  - Entry struct {inst, imm, fmt, illegal}.
- Sub-module imm_fmt_decode, parametrised on XLEN: purely combinational inst -> {imm, fmt, illegal}.
- imm_gen_pipe instantiates imm_fmt_decode once and holds the skid-buffer control.

Test Plan:
- ld x5,-8(x2), inst 0xFF813283, XLEN=64 -> 1 cycle later out_imm=0xFFFFFFFFFFFFFFF8, out_fmt=FMT_I, out_illegal=0.
- beq x0,x0,-4, inst 0xFE000EE3 -> out_imm=0xFFFFFFFFFFFFFFFC, FMT_B. lui x1,0x80000, inst 0x800000B7 -> XLEN=64 gives 0xFFFFFFFF80000000, XLEN=32 gives 0x80000000.
- slli x1,x1,63, inst 0x03F09093, XLEN=64 -> out_imm=63, FMT_I. inst 0x0000007F -> out_illegal=1, FMT_ILL, out_imm=0.
- SKID=1 backpressure: out_ready=0 while pushing A,B,C -> A and B accepted, in_ready=0 the cycle after B, C held. Raise out_ready -> A,B,C emerge in order on consecutive cycles, each exactly once.
- Buffer full with in_valid=1 and flush=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears at the output.
- Assert rst asynchronously mid-stream with two entries held -> out_valid drops to 0 before the next clk edge. After release, a fresh ld decodes correctly with 1-cycle latency.
